// File: rtl/mul_pkg.sv
// Shared types for the iterative RV32M multiply unit: operation encoding,
// FSM state encoding and helpers deciding which operands are signed.
package mul_pkg;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mul_op_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        NEG_IN  = 3'd1,
        RUN     = 3'd2,
        NEG_OUT = 3'd3,
        DONE    = 3'd4
    } mul_state_e;

    function automatic logic op_signed_a(input mul_op_e op);
        return (op == MULH) || (op == MULHSU);
    endfunction

    function automatic logic op_signed_b(input mul_op_e op);
        return (op == MULH);
    endfunction

endpackage

// File: rtl/adder_n_bit.sv
// Ripple-carry adder; add_one is the carry-in, so ~x + 0 with add_one=1
// yields the two's-complement negation of x.
module adder_n_bit #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             add_one,
    output logic [WIDTH-1:0] sum
);

    logic [WIDTH-1:0] carry;

    assign carry[0] = add_one;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign sum[gi] = a[gi] ^ b[gi] ^ carry[gi];
            // The carry out of the top bit is dropped: arithmetic is modulo 2^WIDTH.
            if (gi < WIDTH - 1) begin : g_carry
                assign carry[gi+1] = (a[gi] & b[gi]) | (a[gi] & carry[gi]) | (b[gi] & carry[gi]);
            end
        end
    endgenerate

endmodule

// File: rtl/iterative_multiplier.sv
// Multi-cycle shift-and-add RV32M multiplier (MUL/MULH/MULHSU/MULHU).
// Optional build macro MUL_EARLY_EXIT_EN: leave RUN once the multiplier is exhausted.
module iterative_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    mul_state_e         state_reg, state_next;
    mul_op_e            op_reg;
    logic               sign_a_reg, sign_b_reg, neg_res_reg;
    logic [WIDTH-1:0]   a_reg, b_reg;
    logic [2*WIDTH-1:0] mcand_reg, prod_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [CW-1:0]      count_reg;
    logic [WIDTH-1:0]   result_reg;
    logic               result_valid_reg;

    logic               accept;
    logic               sign_a_in, sign_b_in;
    logic [WIDTH-1:0]   neg_a, neg_b, abs_a, abs_b;
    logic               negating;
    logic [2*WIDTH-1:0] wide_a, wide_b, wide_sum;
    logic [2*WIDTH-1:0] final_prod;
    logic [WIDTH-1:0]   mplier_shift;
    logic [WIDTH-1:0]   result_sel;
    logic               run_exit;

    assign start_ready  = (state_reg == IDLE) && !rst;
    assign accept       = start_valid && start_ready;
    assign result_valid = result_valid_reg;
    assign result       = result_reg;

    assign sign_a_in = op_signed_a(mul_op_e'(op)) & a[WIDTH-1];
    assign sign_b_in = op_signed_b(mul_op_e'(op)) & b[WIDTH-1];

    adder_n_bit #(.WIDTH(WIDTH)) u_neg_a (
        .a       (~a_reg),
        .b       ({WIDTH{1'b0}}),
        .add_one (1'b1),
        .sum     (neg_a)
    );

    adder_n_bit #(.WIDTH(WIDTH)) u_neg_b (
        .a       (~b_reg),
        .b       ({WIDTH{1'b0}}),
        .add_one (1'b1),
        .sum     (neg_b)
    );

    // MIN_INT negates to itself, which is exactly 2^(W-1) read as unsigned.
    assign abs_a = sign_a_reg ? neg_a : a_reg;
    assign abs_b = sign_b_reg ? neg_b : b_reg;

    // One wide adder shared between accumulate (RUN) and final negate (NEG_OUT).
    assign negating = (state_reg == NEG_OUT);
    assign wide_a   = negating ? ~prod_reg : prod_reg;
    assign wide_b   = negating ? {(2*WIDTH){1'b0}} : mcand_reg;

    adder_n_bit #(.WIDTH(2*WIDTH)) u_acc (
        .a       (wide_a),
        .b       (wide_b),
        .add_one (negating),
        .sum     (wide_sum)
    );

    assign final_prod   = neg_res_reg ? wide_sum : prod_reg;
    assign result_sel   = (op_reg == MUL) ? final_prod[WIDTH-1:0] : final_prod[2*WIDTH-1:WIDTH];
    assign mplier_shift = mplier_reg >> 1;

`ifdef MUL_EARLY_EXIT_EN
    assign run_exit = (count_reg == LAST_COUNT) || (mplier_shift == {WIDTH{1'b0}});
`else
    assign run_exit = (count_reg == LAST_COUNT);
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = NEG_IN;
            NEG_IN:  state_next = RUN;
            RUN:     if (run_exit) state_next = NEG_OUT;
            NEG_OUT: state_next = DONE;
            DONE:    if (result_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= IDLE;
            op_reg           <= MUL;
            sign_a_reg       <= 1'b0;
            sign_b_reg       <= 1'b0;
            neg_res_reg      <= 1'b0;
            a_reg            <= '0;
            b_reg            <= '0;
            mcand_reg        <= '0;
            mplier_reg       <= '0;
            prod_reg         <= '0;
            count_reg        <= '0;
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        op_reg      <= mul_op_e'(op);
                        a_reg       <= a;
                        b_reg       <= b;
                        sign_a_reg  <= sign_a_in;
                        sign_b_reg  <= sign_b_in;
                        neg_res_reg <= sign_a_in ^ sign_b_in;
                    end
                end
                NEG_IN: begin
                    mcand_reg  <= {{WIDTH{1'b0}}, abs_a};
                    mplier_reg <= abs_b;
                    prod_reg   <= '0;
                    count_reg  <= '0;
                end
                RUN: begin
                    if (mplier_reg[0]) prod_reg <= wide_sum;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_shift;
                    count_reg  <= count_reg + CW'(1);
                end
                NEG_OUT: begin
                    prod_reg         <= final_prod;
                    result_reg       <= result_sel;
                    result_valid_reg <= 1'b1;
                end
                DONE: begin
                    if (result_ready) result_valid_reg <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_multiplier.sv
// Self-checking bench for iterative_multiplier: directed corner cases plus a
// random sweep, checked against a plain 64-bit arithmetic reference model.
module tb_iterative_multiplier;
    import mul_pkg::*;

    localparam int W = 32;
    localparam int BUDGET = 40;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_valid;
    logic          start_ready;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          result_valid;
    logic          result_ready;
    logic [W-1:0]  result;

    int total = 0;
    int bad   = 0;

    iterative_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .op           (op),
        .a            (a),
        .b            (b),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: sign/zero-extend to 2W bits and multiply modulo 2^(2W).
    function automatic logic [W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] x,
                                                 input logic [W-1:0] y);
        logic [2*W-1:0] ex, ey, p;
        logic sx, sy;
        sx = (o == 2'd1) || (o == 2'd2);
        sy = (o == 2'd1);
        ex = sx ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
        ey = sy ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
        p  = ex * ey;
        return (o == 2'd0) ? p[W-1:0] : p[2*W-1:W];
    endfunction

    function automatic int ref_latency(input logic [1:0] o, input logic [W-1:0] y);
`ifdef MUL_EARLY_EXIT_EN
        logic [W-1:0] mag;
        int n;
        mag = ((o == 2'd1) && y[W-1]) ? (~y + 1) : y;
        n = 1;
        for (int i = 0; i < W; i++) if (mag[i]) n = i + 1;
        return 2 + n;
`else
        return W + 2;
`endif
    endfunction

    // Called #1 after a posedge with the unit idle.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input int hold);
        logic [W-1:0] exp_res;
        logic [W-1:0] held;
        int exp_lat;
        int lat;
        exp_res = ref_result(o, x, y);
        exp_lat = ref_latency(o, y);
        chk("start_ready_idle", start_ready, 1);
        op = o; a = x; b = y; start_valid = 1'b1; result_ready = 1'b0;
        @(posedge clk); #1;
        start_valid = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom_range(0, 3));
        lat = 0;
        while (lat < BUDGET) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 1) chk("start_ready_busy", start_ready, 0);
            if (result_valid) break;
        end
        chk("latency", lat, exp_lat);
        chk("result", result, exp_res);
        held = result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("hold_valid", result_valid, 1);
            chk("hold_result", result, held);
            chk("hold_start_ready", start_ready, 0);
        end
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        chk("valid_after_xfer", result_valid, 0);
        chk("ready_after_xfer", start_ready, 1);
        $display("txn op=%0d a=%h b=%h result=%h expected=%h latency=%0d expected_latency=%0d",
                 o, x, y, held, exp_res, lat, exp_lat);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic [1:0] ro;
        logic [W-1:0] corners [6];
        int stale;

        rst = 1'b1; start_valid = 1'b0; result_ready = 1'b0; op = '0; a = '0; b = '0;
        corners[0] = 32'h0000_0000; corners[1] = 32'h0000_0001; corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF; corners[5] = 32'h0000_0002;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_start_ready", start_ready, 0);
        chk("rst_result_valid", result_valid, 0);
        chk("rst_result", result, 0);
        rst = 1'b0;
        #1;
        chk("idle_start_ready", start_ready, 1);

        run_op(2'd0, 32'd7, 32'd6, 0);
        run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 0);
        run_op(2'd1, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(2'd0, 32'd5, 32'd1, 0);
        run_op(2'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 0);
        run_op(2'd3, 32'd9, 32'h8000_0000, 0);
        run_op(2'd0, 32'h1234_5678, 32'h0000_0000, 0);

        // Consumer stalls for 5 cycles in DONE, then the next op runs normally.
        run_op(2'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5);
        run_op(2'd0, 32'd3, 32'd11, 0);

        // Reset while RUN is partway through; no result may surface afterwards.
        op = 2'd3; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; start_valid = 1'b1;
        @(posedge clk); #1;
        start_valid = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_result_valid", result_valid, 0);
        chk("midrst_start_ready_in_rst", start_ready, 0);
        rst = 1'b0;
        #1;
        chk("midrst_start_ready", start_ready, 1);
        chk("midrst_result", result, 0);
        stale = 0;
        repeat (BUDGET) begin
            @(posedge clk); #1;
            if (result_valid) stale++;
        end
        chk("midrst_no_stale", stale, 0);
        $display("txn reset mid-run stale_results=%0d", stale);

        run_op(2'd0, 32'd100, 32'd200, 0);

        // Random sweep, mixing in corner operands.
        for (int n = 0; n < 24; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 32'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : 32'($urandom);
            if ($urandom_range(0, 4) == 0) rb = rb >> $urandom_range(1, 31);
            run_op(ro, ra, rb, $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
